// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues word fetches, buffers returned words for decode.
// Optional build macro IFU_MISALIGN_CHK_EN traps misaligned redirect targets into HALT.
module ifu_fetch #(
  parameter int                  PC_WIDTH   = 64,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 64'h8000_0000,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  halt_req,
  output logic                  halted,
  output logic                  misalign_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // the request holds valid/addr until accepted unless a redirect or halt flushes fetch.
  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic [INST_WIDTH-1:0] fifo_inst_q [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst_d [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   fifo_pc_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   fifo_pc_d [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   pcq_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   pcq_d [FIFO_DEPTH];
  logic                  misalign_q, misalign_d;

  logic [PC_WIDTH-1:0] redir_pc;
  logic                bad_align, stop, redir, flush;
  logic                req_fire, rsp_drop, enq, deq;
  logic [CW:0]         credit_used;

`ifdef IFU_MISALIGN_CHK_EN
  assign redir_pc  = redirect_pc;
  assign bad_align = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc  = redirect_pc & ~PC_WIDTH'(3);
  assign bad_align = 1'b0;
`endif

  // Halt (or a trapped misaligned redirect) beats a plain redirect in the same cycle.
  assign stop  = (state_q == RUN) && (halt_req || bad_align);
  assign redir = (state_q == RUN) && redirect_valid && !stop;
  assign flush = stop || redir;

  // Credits cover both buffered and in-flight words, so a returning word always has a slot.
  assign credit_used    = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign imem_req_valid = (state_q == RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop   = imem_rsp_valid && (drop_q != '0);
  assign enq        = imem_rsp_valid && !rsp_drop && (state_q == RUN) && !flush;
  assign inst_valid = (fifo_cnt_q != '0);
  assign deq        = inst_valid && inst_ready && !flush;

  assign inst         = fifo_inst_q[rd_ptr_q];
  assign inst_pc      = fifo_pc_q[rd_ptr_q];
  assign halted       = (state_q == HALT) && (inflight_q == '0) && (fifo_cnt_q == '0);
  assign misalign_err = misalign_q;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    inflight_d  = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d      = drop_q;
    fifo_cnt_d  = fifo_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    pcq_rd_d    = pcq_rd_q;
    pcq_wr_d    = pcq_wr_q;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    pcq_d       = pcq_q;
    misalign_d  = misalign_q || ((state_q == RUN) && bad_align);

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (stop) state_d = HALT;
      default: state_d = HALT;
    endcase

    if (redir) fetch_pc_d = redir_pc;
    else if (req_fire) fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);

    // The PC queue tracks every outstanding fetch, dropped or not, in issue order.
    if (req_fire) begin
      pcq_d[pcq_wr_q] = fetch_pc_q;
      pcq_wr_d        = pcq_wr_q + AW'(1);
    end
    if (imem_rsp_valid) pcq_rd_d = pcq_rd_q + AW'(1);

    if (rsp_drop) drop_d = drop_q - CW'(1);
    if (flush) drop_d = inflight_d;

    if (flush) begin
      fifo_cnt_d = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (enq) begin
        fifo_inst_d[wr_ptr_q] = imem_rsp_data;
        fifo_pc_d[wr_ptr_q]   = pcq_q[pcq_rd_q];
        wr_ptr_d              = wr_ptr_q + AW'(1);
      end
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
        pcq_q[i]       <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      fifo_cnt_q  <= fifo_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      pcq_rd_q    <= pcq_rd_d;
      pcq_wr_q    <= pcq_wr_d;
      misalign_q  <= misalign_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
      pcq_q       <= pcq_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: in-order memory responder plus per-scenario checking tasks.
module tb_ifu_fetch;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid, halt_req, halted, misalign_err;
  logic [63:0] redirect_pc;

  int          total = 0;
  int          bad = 0;
  logic        rsp_hold = 1'b0;
  logic [63:0] pend_q[$];
  logic [63:0] obs_pc_q[$];
  logic [31:0] obs_inst_q[$];

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Memory: answers each accepted request in the cycle after it, in order, unless held.
  initial begin
    logic        fire_s;
    logic [63:0] addr_s;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      fire_s = imem_req_valid & imem_req_ready;
      addr_s = imem_req_addr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend_q.delete();
        imem_rsp_valid = 1'b0;
      end else begin
        if (fire_s) pend_q.push_back(addr_s);
        if (!rsp_hold && pend_q.size() > 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_q.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
      end
    end
  end

  task automatic drive_idle();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Records consumed words; called on a negedge with inputs already set.
  task automatic gather(input int n, input int budget);
    obs_pc_q.delete();
    obs_inst_q.delete();
    for (int c = 0; c < budget && obs_pc_q.size() < n; c++) begin
      if (inst_valid && inst_ready) begin
        obs_pc_q.push_back(inst_pc);
        obs_inst_q.push_back(inst);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    total++; if (imem_req_addr !== RPC) begin bad++; $display("FAIL rst_req_addr: got %h want %h", imem_req_addr, RPC); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_inst: got %h want 0", inst); end
    total++; if (inst_pc !== 64'h0) begin bad++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", halted); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rst_misalign: got %b want 0", misalign_err); end
    rst_n = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL boot_req_valid: got %b want 0", imem_req_valid); end
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL cyc1_req_valid: got %b want 1", imem_req_valid); end
    total++; if (imem_req_addr !== RPC) begin bad++; $display("FAIL cyc1_req_addr: got %h want %h", imem_req_addr, RPC); end
  endtask

  task automatic test_stream();
    logic [63:0] e;
    drive_idle();
    rsp_hold = 1'b0;
    do_reset();
    gather(3, 30);
    total++; if (obs_pc_q.size() != 3) begin bad++; $display("FAIL stream_count: got %0d want 3", obs_pc_q.size()); end
    for (int k = 0; k < obs_pc_q.size(); k++) begin
      e = RPC + 64'(4 * k);
      total++; if (obs_pc_q[k] !== e) begin bad++; $display("FAIL stream_pc%0d: got %h want %h", k, obs_pc_q[k], e); end
      total++; if (obs_inst_q[k] !== mem_word(e)) begin bad++; $display("FAIL stream_inst%0d: got %h want %h", k, obs_inst_q[k], mem_word(e)); end
    end
  endtask

  task automatic test_stall();
    int          nreq = 0;
    int          unstable = 0;
    logic        seen = 1'b0;
    logic [63:0] hold_pc = '0;
    logic [31:0] hold_inst = '0;
    logic [63:0] e;
    drive_idle();
    inst_ready = 1'b0;
    rsp_hold = 1'b0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) nreq++;
      if (inst_valid && !seen) begin seen = 1'b1; hold_pc = inst_pc; hold_inst = inst; end
      else if (seen && (!inst_valid || inst_pc !== hold_pc || inst !== hold_inst)) unstable++;
    end
    total++; if (nreq != 2) begin bad++; $display("FAIL stall_reqs: got %0d want 2", nreq); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
    total++; if (unstable != 0) begin bad++; $display("FAIL stall_hold: got %0d changes want 0", unstable); end
    total++; if (inst_pc !== RPC) begin bad++; $display("FAIL stall_head_pc: got %h want %h", inst_pc, RPC); end
    inst_ready = 1'b1;
    gather(4, 30);
    total++; if (obs_pc_q.size() != 4) begin bad++; $display("FAIL stall_count: got %0d want 4", obs_pc_q.size()); end
    for (int k = 0; k < obs_pc_q.size(); k++) begin
      e = RPC + 64'(4 * k);
      total++; if (obs_pc_q[k] !== e) begin bad++; $display("FAIL stall_pc%0d: got %h want %h", k, obs_pc_q[k], e); end
      total++; if (obs_inst_q[k] !== mem_word(e)) begin bad++; $display("FAIL stall_inst%0d: got %h want %h", k, obs_inst_q[k], mem_word(e)); end
    end
  endtask

  task automatic test_redirect();
    int          nreq = 0;
    logic [63:0] e;
    drive_idle();
    rsp_hold = 1'b1;
    do_reset();
    for (int c = 0; c < 20 && nreq < 2; c++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) nreq++;
    end
    @(negedge clk);
    total++; if (nreq != 2) begin bad++; $display("FAIL redir_inflight: got %0d want 2", nreq); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_credit: got %b want 0", imem_req_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    rsp_hold = 1'b0;
    gather(2, 40);
    total++; if (obs_pc_q.size() != 2) begin bad++; $display("FAIL redir_count: got %0d want 2", obs_pc_q.size()); end
    for (int k = 0; k < obs_pc_q.size(); k++) begin
      e = 64'h8000_0100 + 64'(4 * k);
      total++; if (obs_pc_q[k] !== e) begin bad++; $display("FAIL redir_pc%0d: got %h want %h", k, obs_pc_q[k], e); end
      total++; if (obs_inst_q[k] !== mem_word(e)) begin bad++; $display("FAIL redir_inst%0d: got %h want %h", k, obs_inst_q[k], mem_word(e)); end
    end
  endtask

  task automatic test_halt();
    int viol = 0;
    int wait_c = 0;
    drive_idle();
    rsp_hold = 1'b1;
    do_reset();
    for (int c = 0; c < 10 && !imem_req_valid; c++) @(negedge clk);
    halt_req       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    @(negedge clk);
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL halt_req_valid: got %b want 0", imem_req_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early: got %b want 0", halted); end
    repeat (3) begin
      @(negedge clk);
      if (imem_req_valid || inst_valid || halted) viol++;
    end
    rsp_hold = 1'b0;
    while (!halted && wait_c < 10) begin
      @(negedge clk);
      wait_c++;
      if (imem_req_valid || inst_valid) viol++;
    end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_done: got %b want 1", halted); end
    repeat (5) begin
      @(negedge clk);
      if (imem_req_valid || inst_valid || !halted) viol++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL halt_quiet: got %0d violations want 0", viol); end
    total++; if (imem_req_addr !== RPC + 64'd4) begin bad++; $display("FAIL halt_pc: got %h want %h", imem_req_addr, RPC + 64'd4); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    drive_idle();
    inst_ready = 1'b0;
    rsp_hold = 1'b0;
    do_reset();
    repeat (8) @(negedge clk);
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL mid_full_valid: got %b want 1", inst_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL mid_req_valid: got %b want 0", imem_req_valid); end
    total++; if (imem_req_addr !== RPC) begin bad++; $display("FAIL mid_req_addr: got %h want %h", imem_req_addr, RPC); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL mid_inst_valid: got %b want 0", inst_valid); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL mid_inst: got %h want 0", inst); end
    total++; if (inst_pc !== 64'h0) begin bad++; $display("FAIL mid_inst_pc: got %h want 0", inst_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    inst_ready = 1'b1;
    gather(2, 30);
    total++; if (obs_pc_q.size() != 2) begin bad++; $display("FAIL mid_count: got %0d want 2", obs_pc_q.size()); end
    for (int k = 0; k < obs_pc_q.size(); k++) begin
      e = RPC + 64'(4 * k);
      total++; if (obs_pc_q[k] !== e) begin bad++; $display("FAIL mid_pc%0d: got %h want %h", k, obs_pc_q[k], e); end
    end
  endtask

  task automatic test_misalign();
    drive_idle();
    rsp_hold = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_err: got %b want 1", misalign_err); end
    for (int c = 0; c < 10 && !halted; c++) @(negedge clk);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL mis_halted: got %b want 1", halted); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL mis_inst_valid: got %b want 0", inst_valid); end
`else
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_err: got %b want 0", misalign_err); end
    gather(2, 30);
    total++; if (obs_pc_q.size() != 2) begin bad++; $display("FAIL mis_count: got %0d want 2", obs_pc_q.size()); end
    if (obs_pc_q.size() > 0) begin
      total++; if (obs_pc_q[0] !== 64'h8000_0100) begin bad++; $display("FAIL mis_pc0: got %h want 8000_0100", obs_pc_q[0]); end
      total++; if (obs_inst_q[0] !== mem_word(64'h8000_0100)) begin bad++; $display("FAIL mis_inst0: got %h want %h", obs_inst_q[0], mem_word(64'h8000_0100)); end
    end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_err_late: got %b want 0", misalign_err); end
`endif
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
